shiftreg_tx_ctrl: RTL and testbench

Sequencing controller that turns the free-running `shiftreg` into a framed, flow-controlled parallel-to-serial transmitter. It accepts WIDTH-bit words over a valid/ready handshake, loads them into a `shiftreg` instance, and counts out WIDTH serial bits MSB-first. It marks those bits with frame/last strobes and inserts a programmable idle gap between words. It sits between a word-producing client and any single-wire serial sink.

---
 rtl/shiftreg_pkg.sv | 17 +
 rtl/shiftreg.sv | 28 ++
 rtl/shiftreg_tx_ctrl.sv | 133 +++++++++++++
 tb/tb_shiftreg_tx_ctrl.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/shiftreg_pkg.sv
// Shared types and counter sizing helpers for the serial transmit controller.
package shiftreg_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_GAP   = 2'd2
  } tx_state_t;

  localparam int MIN_CNT_W = 1;

  // Counter width able to hold 0..n-1; never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n < 2) ? MIN_CNT_W : $clog2(n);
  endfunction

endpackage

// File: rtl/shiftreg.sv
// Free-running MSB-first shift register with a synchronous parallel fill.
module shiftreg #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             fill,
  input  logic [WIDTH-1:0] fill_data,
  input  logic             ser_in,
  output logic             msb
);

  logic [WIDTH-1:0] sr;

  // Shifts on every edge unless a fill is requested.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sr <= '0;
    end else if (fill) begin
      sr <= fill_data;
    end else begin
      sr <= {sr[WIDTH-2:0], ser_in};
    end
  end

  assign msb = sr[WIDTH-1];

endmodule

// File: rtl/shiftreg_tx_ctrl.sv
// Framed, flow-controlled parallel-to-serial transmitter built around shiftreg:
// valid/ready word intake, MSB-first bit sequencing and an optional idle gap.
module shiftreg_tx_ctrl
  import shiftreg_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int GAP   = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_valid,
  output logic             o_ready,
  output logic             o_sdata,
  output logic             o_sframe,
  output logic             o_slast,
  output logic             o_busy
);

  localparam int BIT_W = cnt_width(WIDTH);
  localparam int GAP_W = cnt_width(GAP);
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(WIDTH - 1);
  localparam logic [GAP_W-1:0] LAST_GAP = GAP_W'((GAP > 0) ? GAP - 1 : 0);
  localparam logic NO_GAP = (GAP == 0);

  tx_state_t        state;
  tx_state_t        state_next;
  logic [BIT_W-1:0] bit_cnt;
  logic [BIT_W-1:0] bit_cnt_next;
  logic [GAP_W-1:0] gap_cnt;
  logic [GAP_W-1:0] gap_cnt_next;
  logic             fill;
  logic             accept;
  logic             sr_msb;
  logic             in_shift;
  logic             at_last_bit;
  logic             at_last_gap;

  assign in_shift    = (state == ST_SHIFT);
  assign at_last_bit = in_shift && (bit_cnt == LAST_BIT);
  assign at_last_gap = (state == ST_GAP) && (gap_cnt == LAST_GAP);

  // Ready is held low during reset even though the state already reads IDLE.
  assign o_ready = !rst && ((state == ST_IDLE) ||
                            (at_last_bit && NO_GAP) ||
                            at_last_gap);

  assign accept = i_valid && o_ready;

  assign o_sframe = in_shift;
  assign o_sdata  = in_shift && sr_msb;
  assign o_slast  = at_last_bit;
  assign o_busy   = (state != ST_IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= ST_IDLE;
      bit_cnt <= '0;
      gap_cnt <= '0;
    end else begin
      state   <= state_next;
      bit_cnt <= bit_cnt_next;
      gap_cnt <= gap_cnt_next;
    end
  end

  always_comb begin
    state_next   = state;
    bit_cnt_next = bit_cnt;
    gap_cnt_next = gap_cnt;
    fill         = 1'b0;

    case (state)
      ST_IDLE: begin
        if (accept) begin
          fill         = 1'b1;
          bit_cnt_next = '0;
          state_next   = ST_SHIFT;
        end
      end

      ST_SHIFT: begin
        if (bit_cnt != LAST_BIT) begin
          bit_cnt_next = bit_cnt + 1'b1;
        end else if (NO_GAP) begin
          // Without a gap the next word may follow with no bubble.
          bit_cnt_next = '0;
          if (accept) begin
            fill = 1'b1;
          end else begin
            state_next = ST_IDLE;
          end
        end else begin
          bit_cnt_next = '0;
          gap_cnt_next = '0;
          state_next   = ST_GAP;
        end
      end

      ST_GAP: begin
        if (gap_cnt != LAST_GAP) begin
          gap_cnt_next = gap_cnt + 1'b1;
        end else begin
          gap_cnt_next = '0;
          if (accept) begin
            fill         = 1'b1;
            bit_cnt_next = '0;
            state_next   = ST_SHIFT;
          end else begin
            state_next = ST_IDLE;
          end
        end
      end

      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // The register keeps shifting zeros outside SHIFT; its contents are ignored there.
  shiftreg #(
    .WIDTH(WIDTH)
  ) u_sr (
    .clk      (clk),
    .rst      (rst),
    .fill     (fill),
    .fill_data(i_data),
    .ser_in   (1'b0),
    .msb      (sr_msb)
  );

endmodule

// File: tb/tb_shiftreg_tx_ctrl.sv
// Bench for shiftreg_tx_ctrl: three configurations driven side by side and
// compared each cycle against a cycle-offset reference model.
module tb_shiftreg_tx_ctrl;

  localparam int N      = 3;
  localparam int IDLE_K = 1000;

  logic       clk;
  logic       rst;
  logic [2:0] valid;
  logic [2:0] ready;
  logic [2:0] sdata;
  logic [2:0] sframe;
  logic [2:0] slast;
  logic [2:0] busy;
  logic [7:0] tx_data [N];

  int wid [N] = '{8, 8, 2};
  int gap [N] = '{0, 3, 0};

  // Model: cycles elapsed since the word in flight was accepted (IDLE_K = none).
  int m_k        [N];
  int m_word     [N];
  int accepts    [N];
  int slast_seen [N];

  int checks = 0;
  int errors = 0;

  shiftreg_tx_ctrl #(.WIDTH(8), .GAP(0)) u_dut0 (
    .clk(clk), .rst(rst), .i_data(tx_data[0]), .i_valid(valid[0]),
    .o_ready(ready[0]), .o_sdata(sdata[0]), .o_sframe(sframe[0]),
    .o_slast(slast[0]), .o_busy(busy[0])
  );

  shiftreg_tx_ctrl #(.WIDTH(8), .GAP(3)) u_dut1 (
    .clk(clk), .rst(rst), .i_data(tx_data[1]), .i_valid(valid[1]),
    .o_ready(ready[1]), .o_sdata(sdata[1]), .o_sframe(sframe[1]),
    .o_slast(slast[1]), .o_busy(busy[1])
  );

  shiftreg_tx_ctrl #(.WIDTH(2), .GAP(0)) u_dut2 (
    .clk(clk), .rst(rst), .i_data(tx_data[2][1:0]), .i_valid(valid[2]),
    .o_ready(ready[2]), .o_sdata(sdata[2]), .o_sframe(sframe[2]),
    .o_slast(slast[2]), .o_busy(busy[2])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic exp_ready(input int d);
    if (rst) return 1'b0;
    return (m_k[d] >= wid[d] + gap[d]) || (m_k[d] == wid[d] + gap[d] - 1);
  endfunction

  task automatic check_output(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    logic fr;
    logic bit_e;
    for (int d = 0; d < N; d++) begin
      fr    = (m_k[d] < wid[d]);
      bit_e = 1'b0;
      if (fr) bit_e = ((m_word[d] >> (wid[d] - 1 - m_k[d])) & 1) != 0;
      check_output($sformatf("dut%0d sframe", d), sframe[d], fr);
      check_output($sformatf("dut%0d sdata", d), sdata[d], bit_e);
      check_output($sformatf("dut%0d slast", d), slast[d], m_k[d] == wid[d] - 1);
      check_output($sformatf("dut%0d busy", d), busy[d], m_k[d] < wid[d] + gap[d]);
      check_output($sformatf("dut%0d ready", d), ready[d], exp_ready(d));
      if (slast[d] === 1'b1) slast_seen[d]++;
    end
  endtask

  // Check this cycle, then advance the model across one rising edge.
  task automatic cycle();
    logic [N-1:0] acc;
    int w [N];
    check_all();
    for (int d = 0; d < N; d++) begin
      acc[d] = valid[d] && exp_ready(d);
      w[d]   = int'(tx_data[d]) & ((1 << wid[d]) - 1);
    end
    @(posedge clk);
    #1;
    for (int d = 0; d < N; d++) begin
      if (acc[d]) begin
        m_k[d]    = 0;
        m_word[d] = w[d];
        accepts[d]++;
      end else if (m_k[d] < IDLE_K) begin
        m_k[d]++;
      end
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  // Offer one word and return right after the edge that accepts it.
  task automatic apply_stimulus(input int d, input int word);
    logic took;
    valid[d]   = 1'b1;
    tx_data[d] = 8'(word);
    for (int n = 0; n < 40; n++) begin
      took = exp_ready(d);
      cycle();
      if (took) return;
    end
    errors++;
    $error("FAIL dut%0d accept: observed no handshake in 40 cycles, expected one", d);
  endtask

  task automatic do_reset();
    #2;
    rst = 1'b1;
    for (int d = 0; d < N; d++) m_k[d] = IDLE_K;
    #1;
    check_all();
    @(posedge clk);
    #1;
    check_all();
    rst = 1'b0;
    #1;
  endtask

  initial begin
    rst   = 1'b1;
    valid = '0;
    for (int d = 0; d < N; d++) begin
      tx_data[d]    = '0;
      m_k[d]        = IDLE_K;
      m_word[d]     = 0;
      accepts[d]    = 0;
      slast_seen[d] = 0;
    end
    #1;
    check_all();
    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;

    $display("[TB] single word 0xA5, no gap");
    apply_stimulus(0, 'hA5);
    valid[0] = 1'b0;
    idle(10);

    $display("[TB] back-to-back 0xFF, 0x00, no gap");
    apply_stimulus(0, 'hFF);
    apply_stimulus(0, 'h00);
    valid[0] = 1'b0;
    idle(12);

    $display("[TB] back-to-back 0x81, 0x81 with gap of 3");
    apply_stimulus(1, 'h81);
    apply_stimulus(1, 'h81);
    valid[1] = 1'b0;
    idle(15);

    $display("[TB] reset during bit 4 of 0xF0, then 0x0F");
    apply_stimulus(0, 'hF0);
    valid[0] = 1'b0;
    idle(3);
    do_reset();
    apply_stimulus(0, 'h0F);
    valid[0] = 1'b0;
    idle(10);

    $display("[TB] two-bit words 0b10, 0b01");
    apply_stimulus(2, 'h2);
    apply_stimulus(2, 'h1);
    valid[2] = 1'b0;
    idle(5);

    $display("[TB] randomized valid toggling");
    for (int d = 0; d < N; d++) begin
      accepts[d]    = 0;
      slast_seen[d] = 0;
    end
    for (int i = 0; i < 400; i++) begin
      for (int d = 0; d < N; d++) begin
        if (!valid[d]) tx_data[d] = 8'($urandom);
        valid[d] = 1'($urandom_range(0, 1));
      end
      cycle();
    end
    valid = '0;
    idle(20);
    for (int d = 0; d < N; d++) begin
      checks++;
      assert (slast_seen[d] == accepts[d]) else begin
        errors++;
        $error("FAIL dut%0d word count: observed %0d words out, expected %0d", d, slast_seen[d], accepts[d]);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
